dtcm_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the 4 KB data TCM (1024 x 32, byte write enables, 1-cycle synchronous read).
- Accepts RV32 load/store requests from the core pipeline over a valid/ready handshake.
- Drives TCM address, byte enables and lane-aligned store data.
- Returns a response with sign/zero-extended load data or an error flag for misaligned or out-of-range accesses.

---
 rtl/dtcm_lsu_pkg.sv | 45 ++++
 rtl/dtcm_lsu_if.sv | 26 ++
 rtl/dtcm_lsu_align.sv | 30 +++
 rtl/dtcm_lsu.sv | 184 ++++++++++++++++++
 tb/tb_dtcm_lsu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dtcm_lsu_pkg.sv
// dtcm_pkg: shared types and constants for the DTCM load/store unit.
//   - funct3 encodings for RV32 loads and stores
//   - lsu_state_e response-path state machine encoding
//   - DTCM_ADDR_BITS: byte-address bits decoded by the 4 KB TCM
//   - helpers for funct3 legality and natural alignment
package dtcm_pkg;

  localparam int DTCM_ADDR_BITS = 12;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSP  = 2'd1,
    HOLD = 2'd2
  } lsu_state_e;

  // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment by access size (funct3[1:0] encodes the size).
  function automatic logic aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dtcm_lsu_if.sv
// dtcm_lsu_if: core-side request/response handshake of the DTCM LSU.
//   req_*: valid/ready request channel (master drives valid and payload)
//   rsp_*: valid/ready response channel (slave drives valid and payload)
// Modports: master = core pipeline, slave = dtcm_lsu.
interface dtcm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dtcm_lsu_align.sv
// dtcm_lsu_align: load-data lane extraction and sign/zero extension.
//   rdata  in  32  raw TCM word
//   offset in  2   byte offset of the load within the word
//   funct3 in  3   load type (LB/LH/LW/LBU/LHU)
//   data   out 32  extended load result (0 for unknown funct3)
module dtcm_lsu_align
  import dtcm_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  // Shift the addressed byte/half down to bit 0, then extend by funct3.
  always_comb begin
    lane = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_W:    data = lane;
      F3_BU:   data = {24'h000000, lane[7:0]};
      F3_HU:   data = {16'h0000, lane[15:0]};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dtcm_lsu.sv
// dtcm_lsu: RV32 load/store unit in front of a 1024x32 data TCM with byte
// write enables and 1-cycle synchronous read.
//   clk, rst_n      clock, asynchronous active-low reset
//   core            dtcm_lsu_if.slave request/response handshake
//   mem_addr        TCM byte address (request address, passed through)
//   mem_wen         TCM byte write enables, nonzero only for legal stores
//   mem_wdata       lane-replicated store data
//   mem_rdata       TCM read data, valid the cycle after the address
//   perf_loads/perf_stores/perf_errs  accepted-request counters, present
//                   only when DTCM_LSU_PERF_EN is defined
module dtcm_lsu
  import dtcm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          ADDR_BITS = DTCM_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  dtcm_lsu_if.slave   core,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DTCM_LSU_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
`endif
);

  lsu_state_e  state_r, state_d;
  logic        accept, req_ok;
  logic [3:0]  lane_wen;
  logic [31:0] lane_wdata;
  logic [1:0]  off_r;
  logic [2:0]  f3_r;
  logic        we_r, err_r;
  logic [31:0] align_data, live_data;
  logic [31:0] hold_data_r;
  logic        hold_err_r;

  assign core.req_ready = (state_r == IDLE) | ((state_r == RSP) & core.rsp_ready);
  assign accept = core.req_valid & core.req_ready;
  assign req_ok = (core.req_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS])
                & f3_legal(core.req_we, core.req_funct3)
                & aligned(core.req_funct3, core.req_addr[1:0]);

  // Store lane enables and replicated data for the request's size.
  always_comb begin
    lane_wen   = 4'b0000;
    lane_wdata = core.req_wdata;
    case (core.req_funct3)
      F3_B: begin
        lane_wen   = 4'b0001 << core.req_addr[1:0];
        lane_wdata = {4{core.req_wdata[7:0]}};
      end
      F3_H: begin
        lane_wen   = 4'b0011 << core.req_addr[1:0];
        lane_wdata = {2{core.req_wdata[15:0]}};
      end
      F3_W: begin
        lane_wen   = 4'b1111;
        lane_wdata = core.req_wdata;
      end
      default: begin
        lane_wen   = 4'b0000;
        lane_wdata = core.req_wdata;
      end
    endcase
  end

  assign mem_addr  = core.req_addr;
  assign mem_wdata = lane_wdata;
  assign mem_wen   = (accept & core.req_we & req_ok) ? lane_wen : 4'b0000;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_d;
  end

  // Next-state logic; RSP with a ready consumer can chain straight into the next request.
  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: begin
        if (accept) state_d = RSP;
        else        state_d = IDLE;
      end
      RSP: begin
        if (!core.rsp_ready) state_d = HOLD;
        else if (accept)     state_d = RSP;
        else                 state_d = IDLE;
      end
      HOLD: begin
        if (core.rsp_ready) state_d = IDLE;
        else                state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request attributes needed one cycle later to shape the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r <= 2'b00;
      f3_r  <= 3'b000;
      we_r  <= 1'b0;
      err_r <= 1'b0;
    end else if (accept) begin
      off_r <= core.req_addr[1:0];
      f3_r  <= core.req_funct3;
      we_r  <= core.req_we;
      err_r <= ~req_ok;
    end
  end

  dtcm_lsu_align u_align (
    .rdata  (mem_rdata),
    .offset (off_r),
    .funct3 (f3_r),
    .data   (align_data)
  );

  // Stores and errors carry no data.
  assign live_data = (we_r | err_r) ? 32'h0000_0000 : align_data;

  // Capture the live response when the consumer stalls; the TCM output will not hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_r <= 32'h0000_0000;
      hold_err_r  <= 1'b0;
    end else if ((state_r == RSP) && !core.rsp_ready) begin
      hold_data_r <= live_data;
      hold_err_r  <= err_r;
    end
  end

  // Response outputs by state.
  always_comb begin
    core.rsp_valid = 1'b0;
    core.rsp_rdata = 32'h0000_0000;
    core.rsp_err   = 1'b0;
    case (state_r)
      IDLE: begin
        core.rsp_valid = 1'b0;
        core.rsp_rdata = 32'h0000_0000;
        core.rsp_err   = 1'b0;
      end
      RSP: begin
        core.rsp_valid = 1'b1;
        core.rsp_rdata = live_data;
        core.rsp_err   = err_r;
      end
      HOLD: begin
        core.rsp_valid = 1'b1;
        core.rsp_rdata = hold_data_r;
        core.rsp_err   = hold_err_r;
      end
      default: begin
        core.rsp_valid = 1'b0;
        core.rsp_rdata = 32'h0000_0000;
        core.rsp_err   = 1'b0;
      end
    endcase
  end

`ifdef DTCM_LSU_PERF_EN
  // Accepted-request counters; an erroring request counts only as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 32'd0;
      perf_stores <= 32'd0;
      perf_errs   <= 32'd0;
    end else if (accept) begin
      if (!req_ok)          perf_errs   <= perf_errs + 32'd1;
      else if (core.req_we) perf_stores <= perf_stores + 32'd1;
      else                  perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dtcm_lsu.sv
// tb_dtcm_lsu: directed bench for dtcm_lsu with a behavioural 1024x32 TCM.
module tb_dtcm_lsu;
  import dtcm_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] tcm_q;
  logic        garbage_en;
  logic [31:0] tcm [1024];
`ifdef DTCM_LSU_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

  int n_cmp;
  int n_bad;
  vec_t vecs[22];
  vec_t seq[4];
  logic [31:0] seq_exp[4];

  dtcm_lsu_if bus ();

  dtcm_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (bus.slave),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DTCM_LSU_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_errs   (perf_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural TCM: byte-enabled write and registered read at the same edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) tcm[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    tcm_q <= tcm[mem_addr[11:2]];
  end

  assign mem_rdata = garbage_en ? 32'hBAD0_BAD0 : tcm_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] ewen,
                               input logic [31:0] ewdata, input logic [31:0] erdata,
                               input logic eerr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_wen = ewen; v.exp_wdata = ewdata; v.exp_rdata = erdata; v.exp_err = eerr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
  endtask

  // One isolated request with rsp_ready high: check the TCM drive, then the response.
  task automatic apply_one(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d req_ready", idx), {31'd0, bus.req_ready}, 32'd1);
    chk($sformatf("v%0d mem_wen", idx), {28'd0, mem_wen}, {28'd0, v.exp_wen});
    if (v.exp_wen != 4'b0000)
      chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk($sformatf("v%0d rsp_valid", idx), {31'd0, bus.rsp_valid}, 32'd1);
    chk($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", idx), {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    garbage_en = 1'b0;
    for (int i = 0; i < 1024; i++) tcm[i] = 32'h0000_0000;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    rst_n = 1'b0;

    //           we    f3      addr           wdata          wen      wdata         rdata          err
    vecs[0]  = mkv(1'b1, F3_W,  32'h0001_0004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0);
    vecs[1]  = mkv(1'b0, F3_W,  32'h0001_0004, 32'h0,         4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[2]  = mkv(1'b1, F3_B,  32'h0001_0007, 32'hAAAA_AA80, 4'b1000, 32'h8080_8080, 32'h0,         1'b0);
    vecs[3]  = mkv(1'b0, F3_B,  32'h0001_0007, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0);
    vecs[4]  = mkv(1'b0, F3_BU, 32'h0001_0007, 32'h0,         4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    vecs[5]  = mkv(1'b0, F3_H,  32'h0001_0003, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
    vecs[6]  = mkv(1'b1, F3_W,  32'h0002_0000, 32'h1234_5678, 4'b0000, 32'h0,         32'h0,         1'b1);
    vecs[7]  = mkv(1'b0, F3_W,  32'h0001_0000, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0);
    vecs[8]  = mkv(1'b0, F3_W,  32'h0001_0004, 32'h0,         4'b0000, 32'h0,         32'h80AD_BEEF, 1'b0);
    vecs[9]  = mkv(1'b1, F3_H,  32'h0001_0002, 32'h5555_8001, 4'b1100, 32'h8001_8001, 32'h0,         1'b0);
    vecs[10] = mkv(1'b0, F3_H,  32'h0001_0002, 32'h0,         4'b0000, 32'h0,         32'hFFFF_8001, 1'b0);
    vecs[11] = mkv(1'b0, F3_HU, 32'h0001_0002, 32'h0,         4'b0000, 32'h0,         32'h0000_8001, 1'b0);
    vecs[12] = mkv(1'b0, F3_W,  32'h0001_0000, 32'h0,         4'b0000, 32'h0,         32'h8001_0000, 1'b0);
    vecs[13] = mkv(1'b0, 3'b011, 32'h0001_0000, 32'h0,        4'b0000, 32'h0,         32'h0,         1'b1);
    vecs[14] = mkv(1'b1, 3'b100, 32'h0001_0000, 32'hFFFF_FFFF, 4'b0000, 32'h0,        32'h0,         1'b1);
    vecs[15] = mkv(1'b0, F3_B,  32'h0001_0003, 32'h0,         4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0);
    vecs[16] = mkv(1'b0, F3_B,  32'h0001_0001, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b0);
    vecs[17] = mkv(1'b1, F3_H,  32'h0001_0005, 32'hFFFF_FFFF, 4'b0000, 32'h0,         32'h0,         1'b1);
    vecs[18] = mkv(1'b0, F3_W,  32'h0000_FFFC, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1);
    vecs[19] = mkv(1'b1, F3_W,  32'h0001_0008, 32'h1111_2222, 4'b1111, 32'h1111_2222, 32'h0,         1'b0);
    vecs[20] = mkv(1'b1, F3_W,  32'h0001_000C, 32'h3333_4444, 4'b1111, 32'h3333_4444, 32'h0,         1'b0);
    vecs[21] = mkv(1'b0, F3_HU, 32'h0001_000E, 32'h0,         4'b0000, 32'h0,         32'h0000_3333, 1'b0);

    // Reset state.
    #12;
    chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) apply_one(vecs[i], i);

    // Back-to-back, including a store followed immediately by a load of the same word.
    seq[0] = mkv(1'b1, F3_W, 32'h0001_0010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
    seq[1] = mkv(1'b0, F3_W, 32'h0001_0010, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
    seq[2] = mkv(1'b0, F3_W, 32'h0001_0008, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
    seq[3] = mkv(1'b0, F3_W, 32'h0001_000C, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);
    seq_exp[0] = 32'h0;
    seq_exp[1] = 32'hCAFE_F00D;
    seq_exp[2] = 32'h1111_2222;
    seq_exp[3] = 32'h3333_4444;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) drive(seq[i]);
      else       bus.req_valid = 1'b0;
      #1;
      if (i < 4) chk($sformatf("b2b%0d req_ready", i), {31'd0, bus.req_ready}, 32'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d rsp_valid", i - 1), {31'd0, bus.rsp_valid}, 32'd1);
        chk($sformatf("b2b%0d rsp_rdata", i - 1), bus.rsp_rdata, seq_exp[i - 1]);
      end
      @(posedge clk);
    end

    // Stalled response: data must survive garbage on the TCM output.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(vecs[8]);
    @(posedge clk);
    @(negedge clk);
    drive(mkv(1'b1, F3_W, 32'h0001_0004, 32'h0, 4'b0, 32'h0, 32'h0, 1'b0));
    #1;
    chk("stall rsp req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("stall rsp mem_wen", {28'd0, mem_wen}, 32'd0);
    chk("stall rsp rdata", bus.rsp_rdata, 32'h80AD_BEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      garbage_en = 1'b1;
      #1;
      chk($sformatf("hold%0d rsp_valid", i), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("hold%0d rsp_rdata", i), bus.rsp_rdata, 32'h80AD_BEEF);
      chk($sformatf("hold%0d req_ready", i), {31'd0, bus.req_ready}, 32'd0);
      chk($sformatf("hold%0d mem_wen", i), {28'd0, mem_wen}, 32'd0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("hold release rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("hold release rsp_rdata", bus.rsp_rdata, 32'h80AD_BEEF);
    @(negedge clk);
    garbage_en = 1'b0;
    #1;
    chk("after hold rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Asynchronous reset while holding a response.
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(vecs[19]);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre-reset hold rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("async reset req_ready", {31'd0, bus.req_ready}, 32'd1);
`ifdef DTCM_LSU_PERF_EN
    chk("reset perf_loads", perf_loads, 32'd0);
    chk("reset perf_stores", perf_stores, 32'd0);
    chk("reset perf_errs", perf_errs, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    apply_one(vecs[8], 100);
    apply_one(mkv(1'b0, F3_W, 32'h0001_0008, 32'h0, 4'b0, 32'h0, 32'h1111_2222, 1'b0), 101);
`ifdef DTCM_LSU_PERF_EN
    chk("perf_loads after", perf_loads, 32'd2);
    chk("perf_stores after", perf_stores, 32'd0);
    chk("perf_errs after", perf_errs, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
